// File: rtl/stream_writer.sv
// stream_writer
//   Pushes one frame of post-collision lattice values into nine
//   distribution BRAMs. Each accepted beat carries the nine directional
//   values of the current raster cell. Value i goes to BRAM i, at the
//   address of the neighbouring cell in direction i. The grid wraps
//   periodically in both axes.
//
//   Direction / BRAM index: 0 C, 1 N, 2 NE, 3 E, 4 SE, 5 S, 6 SW, 7 W, 8 NW
//   (north = vert-1, east = hor+1). Cell address = vert*HPIXELS + hor.
//
// Ports
//   clk_in          sole clock, rising edge
//   rst_in          synchronous active-high reset
//   start_in        begin one frame (honoured only while idle)
//   valid_in        data_in holds the next cell's nine values
//   data_in         per-direction values
//   ready_out       a beat is accepted this cycle when valid_in is high
//   we_out          per-BRAM write enable (registered)
//   addr_out        per-BRAM write address (registered)
//   data_out        per-BRAM write data (registered)
//   busy_out        frame in progress
//   frame_done_out  one-cycle pulse, coincides with the last cell's writes
module stream_writer #(
   parameter int HPIXELS    = 205,
   parameter int VPIXELS    = 154,
   parameter int DATA_WIDTH = 16
) (
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic                                 start_in,
   input  logic                                 valid_in,
   input  logic [8:0][DATA_WIDTH-1:0]           data_in,
   output logic                                 ready_out,
   output logic [8:0]                           we_out,
   output logic [8:0][$clog2(HPIXELS*VPIXELS)-1:0] addr_out,
   output logic [8:0][DATA_WIDTH-1:0]           data_out,
   output logic                                 busy_out,
   output logic                                 frame_done_out
);

   localparam int HOR_SIZE  = $clog2(HPIXELS);
   localparam int VERT_SIZE = $clog2(VPIXELS);
   localparam int BRAM_SIZE = $clog2(HPIXELS*VPIXELS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                     state, next_state;
   logic [HOR_SIZE-1:0]        hor, hor_m, hor_p;
   logic [VERT_SIZE-1:0]       vert, vert_m, vert_p;
   logic                       accept;
   logic                       last_col, last_row;
   logic [8:0][BRAM_SIZE-1:0]  nb_addr;

   function automatic logic [BRAM_SIZE-1:0] cell_addr(
      input logic [HOR_SIZE-1:0]  h,
      input logic [VERT_SIZE-1:0] v
   );
      logic [31:0] a;
      a = 32'(v) * 32'(HPIXELS) + 32'(h);
      return a[BRAM_SIZE-1:0];
   endfunction

   assign last_col = (hor  == HOR_SIZE'(HPIXELS-1));
   assign last_row = (vert == VERT_SIZE'(VPIXELS-1));

   // Periodic neighbour coordinates.
   always_comb begin
      hor_m  = (hor  == '0) ? HOR_SIZE'(HPIXELS-1)  : hor - 1'b1;
      hor_p  = last_col     ? '0                    : hor + 1'b1;
      vert_m = (vert == '0) ? VERT_SIZE'(VPIXELS-1) : vert - 1'b1;
      vert_p = last_row     ? '0                    : vert + 1'b1;
   end

   always_comb begin
      nb_addr[0] = cell_addr(hor,   vert);
      nb_addr[1] = cell_addr(hor,   vert_m);
      nb_addr[2] = cell_addr(hor_p, vert_m);
      nb_addr[3] = cell_addr(hor_p, vert);
      nb_addr[4] = cell_addr(hor_p, vert_p);
      nb_addr[5] = cell_addr(hor,   vert_p);
      nb_addr[6] = cell_addr(hor_m, vert_p);
      nb_addr[7] = cell_addr(hor_m, vert);
      nb_addr[8] = cell_addr(hor_m, vert_m);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state     = state;
      ready_out      = 1'b0;
      busy_out       = 1'b0;
      frame_done_out = 1'b0;
      accept         = 1'b0;
      case (state)
         IDLE: begin
            if (start_in) next_state = RUN;
         end
         RUN: begin
            ready_out = 1'b1;
            busy_out  = 1'b1;
            accept    = valid_in;
            if (valid_in && last_col && last_row) next_state = DONE;
         end
         DONE: begin
            busy_out       = 1'b1;
            frame_done_out = 1'b1;
            next_state     = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Raster counters: cleared on frame start, advanced per accepted beat.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hor  <= '0;
         vert <= '0;
      end else if (state == IDLE && start_in) begin
         hor  <= '0;
         vert <= '0;
      end else if (accept) begin
         hor <= hor_p;
         if (last_col) vert <= vert_p;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         we_out   <= '0;
         addr_out <= '0;
         data_out <= '0;
      end else begin
         we_out <= accept ? '1 : '0;
         if (accept) begin
            addr_out <= nb_addr;
            data_out <= data_in;
         end
      end
   end

endmodule

// File: doc/stream_writer.md
STREAM_WRITER -- requirements
Module: stream_writer

Interface
REQ-001 Parameters (name, default, meaning), one per line; all SHALL be honoured:
  HPIXELS, 205, grid width in cells
  VPIXELS, 154, grid height in cells
  DATA_WIDTH, 16, width of one distribution value
REQ-002 Derived widths SHALL be HOR_SIZE=$clog2(HPIXELS), VERT_SIZE=$clog2(VPIXELS), BRAM_SIZE=$clog2(HPIXELS*VPIXELS).
REQ-003 Ports (name, direction, width, meaning), one per line; one clock, reset synchronous active-high:
  clk_in  input  1  sole clock, all state on rising edge
  rst_in  input  1  synchronous active-high reset
  start_in  input  1  begin one frame of write-back
  valid_in  input  1  data_in holds the next cell's 9 post-collision values
  data_in  input  [8:0][DATA_WIDTH-1:0]  values per direction, index order below
  ready_out  output  1  block accepts a beat this cycle
  we_out  output  [8:0]  per-BRAM write enable
  addr_out  output  [8:0][BRAM_SIZE-1:0]  per-BRAM write address
  data_out  output  [8:0][DATA_WIDTH-1:0]  per-BRAM write data
  busy_out  output  1  frame in progress
  frame_done_out  output  1  one-cycle pulse, frame fully written

Function
REQ-004 Direction/BRAM index SHALL be: 0 center, 1 north, 2 northeast, 3 east, 4 southeast, 5 south, 6 southwest, 7 west, 8 northwest; north = vert-1, east = hor+1.
REQ-005 Cell address SHALL be vert*HPIXELS+hor, truncated to BRAM_SIZE bits.
REQ-006 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start_in; RUN->DONE on acceptance of cell (HPIXELS-1, VPIXELS-1); DONE->IDLE unconditionally after one cycle.
REQ-007 Entering RUN SHALL clear the internal hor/vert raster counters to (0,0).
REQ-008 ready_out SHALL equal 1 exactly when state is RUN; a beat is accepted when valid_in & ready_out.
REQ-009 Each accepted beat SHALL be cell (hor,vert) of the raster counters; counters then advance hor+1, wrapping HPIXELS-1 -> 0 with vert+1.
REQ-010 Push streaming: for an accepted beat, addr_out[i] SHALL be the address of the neighbour of (hor,vert) in direction i, data_out[i] = data_in[i], we_out = 9'h1FF.
REQ-011 Periodic wrap SHALL apply: hor-1 at 0 -> HPIXELS-1; hor+1 at HPIXELS-1 -> 0; vert-1 at 0 -> VPIXELS-1; vert+1 at VPIXELS-1 -> 0.
REQ-012 Write outputs SHALL be registered: latency exactly 1 cycle from acceptance edge to we_out/addr_out/data_out valid.
REQ-013 Cycles with no accepted beat SHALL drive we_out=0; addr_out/data_out hold last value.
REQ-014 valid_in outside RUN SHALL be ignored (no write, no counter change).
REQ-015 start_in in RUN or DONE SHALL be ignored; start_in in IDLE with valid_in high SHALL not accept that cycle.
REQ-016 busy_out SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-017 frame_done_out SHALL be 1 exactly in the DONE cycle, coinciding with the last cell's writes on we_out.
REQ-018 Bubbles (valid_in low in RUN) SHALL stall the counters without limit; no timeout.

Reset
REQ-019 On rst_in: state IDLE, counters (0,0), we_out=0, addr_out=0, data_out=0, ready_out=0, busy_out=0, frame_done_out=0.
REQ-020 rst_in SHALL dominate start_in and valid_in in the same cycle; reset mid-frame SHALL abandon the frame with no further writes and no frame_done_out pulse.

Verification (HPIXELS=4, VPIXELS=3, DATA_WIDTH=16)
REQ-021 Reset then start_in, one beat data_in[i]=i -> next cycle we_out=1FF, addr_out[0..8]={0,8,9,1,5,4,7,3,11}, data_out[i]=i.
REQ-022 12 back-to-back beats -> last beat writes addr_out={11,7,4,8,0,3,2,10,6}, frame_done_out high that cycle only, busy_out low and ready_out low next cycle.
REQ-023 valid_in toggled 1/0 across frame -> exactly 12 write cycles, we_out=0 in bubbles, frame_done_out after 12th write.
REQ-024 valid_in high while IDLE for 5 cycles, and start_in pulsed during RUN -> no writes in IDLE, counters unaffected by start_in.
REQ-025 rst_in asserted after 5 beats -> next cycle all outputs zero, state IDLE; new start_in restarts at cell (0,0) (addr_out[0]=0).
REQ-026 Each cell written once per frame: scoreboard confirms every address receives exactly one write per BRAM index over a full frame.
